// File: rtl/arm_isa_defs.sv
// Shared ARM subset constants, loader FSM encoding and descriptor payload.
package arm_isa_defs;

  localparam logic [1:0] KIND_DP  = 2'b00;
  localparam logic [1:0] KIND_MEM = 2'b01;
  localparam logic [1:0] KIND_BR  = 2'b10;
  localparam logic [1:0] KIND_ILL = 2'b11;

  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  // I=0 (imm offset), P=1, U=1, B=0 (word), W=0
  localparam logic [4:0] MEM_FLAGS = 5'b01100;
  localparam logic [1:0] BR_FUNCT  = 2'b10;

  localparam logic [3:0] COND_AL = 4'b1110;

  typedef enum logic [1:0] {
    ST_ACCEPT = 2'd0,
    ST_WRITE  = 2'd1,
    ST_DONE   = 2'd2,
    ST_ERR    = 2'd3
  } state_t;

  typedef struct packed {
    logic [1:0]  kind;
    logic [3:0]  cond;
    logic [3:0]  cmd;
    logic        s;
    logic        imm;
    logic        load;
    logic [3:0]  rn;
    logic [3:0]  rd;
    logic [11:0] src2;
    logic [23:0] off24;
  } desc_t;

endpackage

// File: rtl/imem_loader_if.sv
// Descriptor stream, instruction-memory write port and loader status.
interface imem_loader_if #(parameter int unsigned ADDR_W = 6);

  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_kind;
  logic [3:0]        in_cond;
  logic [3:0]        in_cmd;
  logic              in_s;
  logic              in_imm;
  logic              in_load;
  logic [3:0]        in_rn;
  logic [3:0]        in_rd;
  logic [11:0]       in_src2;
  logic [23:0]       in_off24;
  logic              in_last;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_reset;
  logic              done;
  logic              error;
  logic [ADDR_W:0]   count;

  modport master (
    output in_valid, in_kind, in_cond, in_cmd, in_s, in_imm, in_load,
           in_rn, in_rd, in_src2, in_off24, in_last,
    input  in_ready, mem_we, mem_addr, mem_wdata, cpu_reset, done, error, count
  );

  modport slave (
    input  in_valid, in_kind, in_cond, in_cmd, in_s, in_imm, in_load,
           in_rn, in_rd, in_src2, in_off24, in_last,
    output in_ready, mem_we, mem_addr, mem_wdata, cpu_reset, done, error, count
  );

endinterface

// File: rtl/instr_encode.sv
// Combinational encoder from a descriptor to an ARM machine word of the supported subset.
module instr_encode
  import arm_isa_defs::*;
(
  input  desc_t       desc,
  output logic [31:0] word,
  output logic        illegal
);

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (desc.kind)
      KIND_DP: begin
        word    = {desc.cond, OP_DP, desc.imm, desc.cmd, desc.s,
                   desc.rn, desc.rd, desc.src2};
        illegal = !(desc.cmd inside {CMD_ADD, CMD_SUB, CMD_AND, CMD_ORR});
      end
      KIND_MEM: begin
        word = {desc.cond, OP_MEM, MEM_FLAGS, desc.load,
                desc.rn, desc.rd, desc.src2};
      end
      KIND_BR: begin
        word = {desc.cond, OP_BR, BR_FUNCT, desc.off24};
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imem_loader.sv
// Streams encoded instructions into instruction memory, holding the CPU in reset until the last one lands.
module imem_loader
  import arm_isa_defs::*;
#(
  parameter int unsigned ADDR_W = 6
) (
  input  logic         clk,
  input  logic         reset,
  imem_loader_if.slave bus
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned DEPTH = 1 << ADDR_W;

  state_t            state;
  logic              ready_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              cpu_reset_q;
  logic              done_q;
  logic              error_q;
  logic [CNT_W-1:0]  count_q;
  logic              last_q;

  desc_t             desc;
  logic [31:0]       enc_word;
  logic              enc_illegal;
  logic              full;

  always_comb begin
    desc       = '0;
    desc.kind  = bus.in_kind;
    desc.cond  = bus.in_cond;
    desc.cmd   = bus.in_cmd;
    desc.s     = bus.in_s;
    desc.imm   = bus.in_imm;
    desc.load  = bus.in_load;
    desc.rn    = bus.in_rn;
    desc.rd    = bus.in_rd;
    desc.src2  = bus.in_src2;
    desc.off24 = bus.in_off24;
  end

  instr_encode u_encode (
    .desc    (desc),
    .word    (enc_word),
    .illegal (enc_illegal)
  );

  // Memory full means every address was written without a last descriptor.
  assign full = (count_q == CNT_W'(DEPTH));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= ST_ACCEPT;
      ready_q     <= 1'b1;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_reset_q <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      count_q     <= '0;
      last_q      <= 1'b0;
    end else begin
      we_q <= 1'b0;
      case (state)
        ST_ACCEPT: begin
          if (bus.in_valid && ready_q) begin
            ready_q <= 1'b0;
            if (enc_illegal || full) begin
              state   <= ST_ERR;
              error_q <= 1'b1;
            end else begin
              state   <= ST_WRITE;
              we_q    <= 1'b1;
              addr_q  <= count_q[ADDR_W-1:0];
              wdata_q <= enc_word;
              last_q  <= bus.in_last;
            end
          end
        end
        ST_WRITE: begin
          count_q <= count_q + CNT_W'(1);
          if (last_q) begin
            state       <= ST_DONE;
            done_q      <= 1'b1;
            cpu_reset_q <= 1'b0;
          end else begin
            state   <= ST_ACCEPT;
            ready_q <= 1'b1;
          end
        end
        ST_DONE: state <= ST_DONE;
        ST_ERR:  state <= ST_ERR;
        default: state <= ST_ERR;
      endcase
    end
  end

  assign bus.in_ready  = ready_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.cpu_reset = cpu_reset_q;
  assign bus.done      = done_q;
  assign bus.error     = error_q;
  assign bus.count     = count_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: directed program cases plus randomized descriptor streams.
module tb_imem_loader;

  localparam int unsigned ADDR_W = 2;
  localparam int unsigned DEPTH  = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [1:0]  kind;
    logic [3:0]  cond;
    logic [3:0]  cmd;
    logic        s;
    logic        imm;
    logic        load;
    logic [3:0]  rn;
    logic [3:0]  rd;
    logic [11:0] src2;
    logic [23:0] off24;
    logic        last;
  } d_t;

  typedef struct {
    int unsigned addr;
    logic [31:0] data;
  } w_t;

  w_t exp_q[$];
  int errors = 0;
  int checks = 0;
  int m_count;
  int m_state; // 0 accepting, 1 done, 2 error

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit legal_cmd(input logic [3:0] c);
    return (c == 4'd4) || (c == 4'd2) || (c == 4'd0) || (c == 4'd12);
  endfunction

  // Reference encoding built from the bit-field positions of the ARM formats.
  function automatic logic [31:0] golden(input d_t d);
    logic [31:0] w;
    w = 32'(d.cond) << 28;
    case (d.kind)
      2'd0: w = w | (32'(d.imm) << 25) | (32'(d.cmd) << 21) | (32'(d.s) << 20)
                  | (32'(d.rn) << 16) | (32'(d.rd) << 12) | 32'(d.src2);
      2'd1: w = w | (32'd1 << 26) | (32'd1 << 24) | (32'd1 << 23) | (32'(d.load) << 20)
                  | (32'(d.rn) << 16) | (32'(d.rd) << 12) | 32'(d.src2);
      default: w = w | (32'hA << 24) | 32'(d.off24);
    endcase
    return w;
  endfunction

  function automatic bit model_accept(input d_t d);
    w_t w;
    if (d.kind == 2'd3 || (d.kind == 2'd0 && !legal_cmd(d.cmd)) || m_count == int'(DEPTH)) begin
      m_state = 2;
      return 1'b0;
    end
    w.addr = m_count;
    w.data = golden(d);
    exp_q.push_back(w);
    m_count++;
    if (d.last) m_state = 1;
    return 1'b1;
  endfunction

  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %h data %h expected no write at %0t",
                 bus.mem_addr, bus.mem_wdata, $time);
      end else begin
        w_t w;
        w = exp_q.pop_front();
        chk("wr_addr", 32'(bus.mem_addr), w.addr);
        chk("wr_data", bus.mem_wdata, w.data);
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_count = 0;
    m_state = 0;
    exp_q.delete();
  endtask

  task automatic check_reset_vals();
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    chk("rst_cpu_reset", 32'(bus.cpu_reset), 32'd1);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_error", 32'(bus.error), 32'd0);
    chk("rst_count", 32'(bus.count), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    bus.in_valid = 1'b0;
    step();
    step();
    model_reset();
    check_reset_vals();
    reset = 1'b1;
  endtask

  task automatic check_status();
    chk("st_in_ready", 32'(bus.in_ready), 32'(m_state == 0));
    chk("st_done", 32'(bus.done), 32'(m_state == 1));
    chk("st_error", 32'(bus.error), 32'(m_state == 2));
    chk("st_cpu_reset", 32'(bus.cpu_reset), 32'(m_state != 1));
    chk("st_count", 32'(bus.count), 32'(m_count));
    chk("st_mem_we", 32'(bus.mem_we), 32'd0);
  endtask

  task automatic drive(input d_t d);
    bus.in_kind  = d.kind;
    bus.in_cond  = d.cond;
    bus.in_cmd   = d.cmd;
    bus.in_s     = d.s;
    bus.in_imm   = d.imm;
    bus.in_load  = d.load;
    bus.in_rn    = d.rn;
    bus.in_rd    = d.rd;
    bus.in_src2  = d.src2;
    bus.in_off24 = d.off24;
    bus.in_last  = d.last;
  endtask

  // Offers one descriptor; returns positioned in the cycle right after the accepting edge.
  task automatic send(input d_t d, input bit hold);
    int n;
    bit wr;
    drive(d);
    bus.in_valid = 1'b1;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    if (n >= 20) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no in_ready expected in_ready within 20 cycles at %0t", $time);
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    wr = model_accept(d);
    if (!hold) bus.in_valid = 1'b0;
    step();
    chk("we_after_accept", 32'(bus.mem_we), 32'(wr));
  endtask

  function automatic d_t mk(input logic [1:0] kind, input logic [3:0] cond, input logic [3:0] cmd,
                            input logic s, input logic imm, input logic load,
                            input logic [3:0] rn, input logic [3:0] rd,
                            input logic [11:0] src2, input logic [23:0] off24, input logic last);
    d_t d;
    d.kind = kind; d.cond = cond; d.cmd = cmd; d.s = s; d.imm = imm; d.load = load;
    d.rn = rn; d.rd = rd; d.src2 = src2; d.off24 = off24; d.last = last;
    return d;
  endfunction

  function automatic d_t rand_desc();
    d_t d;
    int k;
    int unsigned pick;
    k = int'($urandom_range(0, 9));
    d.kind  = (k < 5) ? 2'd0 : (k < 8) ? 2'd1 : (k < 9) ? 2'd2 : 2'd3;
    pick    = $urandom_range(0, 9);
    d.cmd   = (pick == 0) ? 4'($urandom) :
              (pick < 4) ? 4'd4 : (pick < 6) ? 4'd2 : (pick < 8) ? 4'd0 : 4'd12;
    d.cond  = 4'($urandom);
    d.s     = 1'($urandom);
    d.imm   = 1'($urandom);
    d.load  = 1'($urandom);
    d.rn    = 4'($urandom);
    d.rd    = 4'($urandom);
    d.src2  = 12'($urandom);
    d.off24 = 24'($urandom);
    d.last  = 1'b0;
    return d;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000 time units");
    $fatal(1, "watchdog");
  end

  initial begin
    d_t d;
    bus.in_valid = 1'b0;
    drive(mk(2'd0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 12'h0, 24'h0, 1'b0));

    // Single ADD R2,R0,#5
    do_reset();
    send(mk(2'd0, 4'hE, 4'b0100, 1'b0, 1'b1, 1'b0, 4'd0, 4'd2, 12'h005, 24'h0, 1'b0), 1'b0);
    chk("add_word_direct", bus.mem_wdata, 32'hE280_2005);
    step();
    check_status();

    // Short program ending in BEQ
    do_reset();
    send(mk(2'd0, 4'hE, 4'b0010, 1'b1, 1'b0, 1'b0, 4'd1, 4'd3, 12'h002, 24'h0, 1'b0), 1'b0);
    chk("subs_word_direct", bus.mem_wdata, 32'hE051_3002);
    step(); check_status();
    send(mk(2'd1, 4'hE, 4'h0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd4, 12'h008, 24'h0, 1'b0), 1'b0);
    chk("ldr_word_direct", bus.mem_wdata, 32'hE590_4008);
    step(); check_status();
    send(mk(2'd1, 4'hE, 4'h0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd4, 12'h008, 24'h0, 1'b0), 1'b0);
    chk("str_word_direct", bus.mem_wdata, 32'hE580_4008);
    step(); check_status();
    send(mk(2'd2, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 12'h000, 24'h000002, 1'b1), 1'b0);
    chk("beq_word_direct", bus.mem_wdata, 32'h0A00_0002);
    chk("beq_addr_direct", 32'(bus.mem_addr), 32'd3);
    chk("cpu_reset_in_last_write", 32'(bus.cpu_reset), 32'd1);
    step(); check_status();
    chk("done_direct", 32'(bus.done), 32'd1);

    // Illegal DP command, then illegal kind; both stick in error
    for (int t = 0; t < 2; t++) begin
      do_reset();
      if (t == 0) d = mk(2'd0, 4'hE, 4'b0001, 1'b0, 1'b0, 1'b0, 4'd1, 4'd1, 12'h001, 24'h0, 1'b0);
      else        d = mk(2'd3, 4'hE, 4'b0100, 1'b0, 1'b0, 1'b0, 4'd1, 4'd1, 12'h001, 24'h0, 1'b1);
      send(d, 1'b1);
      chk("error_direct", 32'(bus.error), 32'd1);
      drive(mk(2'd0, 4'hE, 4'b0100, 1'b0, 1'b1, 1'b0, 4'd0, 4'd2, 12'h005, 24'h0, 1'b1));
      for (int i = 0; i < 4; i++) step();
      bus.in_valid = 1'b0;
      check_status();
    end

    // Fill the memory: fifth descriptor errors, or fourth with last completes
    for (int t = 0; t < 2; t++) begin
      do_reset();
      for (int i = 0; i < 5 - t; i++) begin
        d = mk(2'd0, 4'hE, 4'b1100, 1'b0, 1'b1, 1'b0, 4'(i), 4'(i + 1), 12'(i * 3), 24'h0,
               1'(t == 1 && i == 3));
        send(d, 1'b0);
        step();
        check_status();
      end
    end

    // Valid held high across a whole program
    do_reset();
    for (int i = 0; i < 4; i++) begin
      d = rand_desc();
      d.kind = 2'd1;
      d.last = 1'(i == 3);
      send(d, 1'b1);
    end
    bus.in_valid = 1'b0;
    step();
    check_status();

    // Reset in the accepting cycle, then reset during WRITE
    do_reset();
    drive(mk(2'd0, 4'hE, 4'b0100, 1'b0, 1'b1, 1'b0, 4'd0, 4'd2, 12'h005, 24'h0, 1'b0));
    bus.in_valid = 1'b1;
    reset = 1'b0;
    step();
    bus.in_valid = 1'b0;
    check_reset_vals();
    reset = 1'b1;
    send(mk(2'd0, 4'hE, 4'b0100, 1'b0, 1'b1, 1'b0, 4'd0, 4'd2, 12'h005, 24'h0, 1'b0), 1'b0);
    reset = 1'b0;
    step();
    model_reset();
    check_reset_vals();
    reset = 1'b1;
    send(mk(2'd1, 4'hE, 4'h0, 1'b0, 1'b0, 1'b1, 4'd7, 4'd9, 12'h0FC, 24'h0, 1'b0), 1'b0);
    step();
    check_status();

    // Randomized programs
    for (int r = 0; r < 12; r++) begin
      int n;
      bit hold;
      do_reset();
      n = int'($urandom_range(1, 6));
      for (int i = 0; i < n; i++) begin
        if (m_state != 0) break;
        d = rand_desc();
        d.last = 1'(i == n - 1 && $urandom_range(0, 2) != 0);
        hold = 1'($urandom);
        send(d, hold);
        if (!hold) begin
          step();
          check_status();
        end
      end
      bus.in_valid = 1'b0;
      step();
      step();
      check_status();
    end

    step();
    step();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Program-side counterpart of the single-cycle ARM control decoder. Accepts instruction descriptions (kind, condition, fields) over a valid/ready stream, encodes each into a 32-bit ARM machine word restricted to the subset the decoder executes (ADD/SUB/AND/ORR, LDR/STR immediate offset, B), and writes the words sequentially into instruction memory. Holds the processor in reset until the program is complete, then releases it.

## Interface
- ADDR_W, 6: word-address width; instruction memory depth is 2**ADDR_W words.
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- in_valid  in  1  descriptor valid
- in_ready  out  1  loader can accept a descriptor this cycle
- in_kind  in  2  00 data-processing, 01 memory, 10 branch, 11 illegal
- in_cond  in  4  condition field, bits [31:28]
- in_cmd  in  4  DP command (0100 ADD, 0010 SUB, 0000 AND, 1100 ORR)
- in_s  in  1  DP set-flags bit
- in_imm  in  1  DP immediate operand select (bit 25)
- in_load  in  1  memory: 1 LDR, 0 STR
- in_rn, in_rd  in  4 each  register fields
- in_src2  in  12  DP Src2 or memory imm12 offset
- in_off24  in  24  branch imm24 word offset
- in_last  in  1  descriptor is the final instruction
- mem_we  out  1  instruction-memory write strobe
- mem_addr  out  ADDR_W  word address
- mem_wdata  out  32  encoded instruction
- cpu_reset  out  1  active-high hold for the processor
- done  out  1  program loaded
- error  out  1  sticky fault
- count  out  ADDR_W+1  words written

## Operation
- FSM states: ACCEPT, WRITE, DONE, ERR.
- ACCEPT: in_ready=1. A transfer occurs when in_valid & in_ready. Descriptor is validated and encoded, the word is registered, and the FSM moves to WRITE (or to ERR).
- WRITE: in_ready=0; mem_we=1 for exactly one cycle with mem_addr=count[ADDR_W-1:0], mem_wdata=registered word. count increments. Next state is DONE if the captured in_last=1, otherwise ACCEPT.
- DONE: done=1, cpu_reset=0, in_ready=0. Stays until reset.
- ERR: error=1, cpu_reset=1, in_ready=0, no writes. Stays until reset.
- Encoding:
  - DP: {cond, 00, imm, cmd, s, rn, rd, src2}
  - MEM: {cond, 01, 0, 1, 1, 0, 0, load, rn, rd, src2[11:0]}, meaning immediate offset, pre-index, add, word, no writeback.
  - B: {cond, 10, 10, off24}
- Errors are detected on the accepted descriptor; the offending descriptor is never written. Error conditions:
  - in_kind=11
  - DP with in_cmd outside {0100, 0010, 0000, 1100}
  - acceptance when count == 2**ADDR_W, i.e. memory full without a prior last.
- Ignored fields per kind: in_s, in_imm, in_cmd for MEM/B; in_load for DP/B; in_rn, in_rd, in_src2 for B; in_off24 for DP/MEM.

## Timing
- Reset values: state=ACCEPT, in_ready=1 (first cycle after reset deasserts), mem_we=0, mem_addr=0, mem_wdata=0, cpu_reset=1, done=0, error=0, count=0.
- Latency: accept at edge N, then mem_we high during cycle N+1. Maximum throughput is one descriptor per 2 cycles.
- Back-to-back: in_valid held high yields accepts on alternating cycles.
- in_ready is a registered function of state only and does not depend on in_valid.
- cpu_reset falls in the cycle after the final WRITE. It never falls in ERR.
- The last word may occupy address 2**ADDR_W-1. count then reaches 2**ADDR_W and DONE is entered without error.
- reset low in any state, including WRITE, returns all outputs to reset values at the next edge. A pending write is dropped.
- in_valid while in_ready=0 is ignored. The upstream must hold the descriptor until accepted.

## Structure
- A shared package/header `arm_isa_defs` holds:
  - kind codes (KIND_DP, KIND_MEM, KIND_BR)
  - cmd codes (CMD_ADD, CMD_SUB, CMD_AND, CMD_ORR)
  - op field constants
  - condition code AL=1110
  - FSM state encoding
- Sub-module `instr_encode`: purely combinational. Takes descriptor fields and produces word[31:0] and illegal. The loader registers its output. It is reusable by the testbench as a golden model.

## Test plan
- Reset, then ADD R2,R0,#5 (kind 00, cond E, cmd 0100, imm 1, rd 2, src2 005, last 0) → mem_we at addr 0, data E2802005, count=1, cpu_reset=1.
- Sequence: SUBS R3,R1,R2 → E0513002; LDR R4,[R0,#8] → E5904008; STR R4,[R0,#8] → E5804008; BEQ off24=000002 with last=1 → 0A000002 at addr 3. Then done=1 and cpu_reset=0 one cycle after the final write.
- Illegal DP cmd 0001, then kind 11 after a fresh reset → no mem_we, error=1, cpu_reset stays 1, in_ready=0 thereafter.
- ADDR_W=2: five descriptors, none last → four writes (addr 0..3), fifth accept sets error. With four descriptors where the fourth is last → done, no error.
- in_valid held high continuously → accepts only on cycles with in_ready=1, alternating with mem_we pulses, and no duplicate writes.
- reset asserted during WRITE → no write that cycle, all outputs at reset values next cycle, next accept writes to addr 0.
